// File: rtl/fir_pkg.sv
// Shared types and constants for the sequenced 64-tap FIR engine.
// State encoding, default widths and the rounding-constant helper.
package fir_pkg;

  localparam int DW   = 12;
  localparam int ADW  = 6;
  localparam int NTAP = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic logic [63:0] rnd_const(input int unsigned sh);
    return 64'd1 << (sh - 1);
  endfunction

endpackage

// File: rtl/coef_ram64x18.sv
// 64-entry coefficient store: synchronous write, asynchronous read.
// Maps onto distributed RAM; contents are not reset.
module coef_ram64x18
  import fir_pkg::*;
#(
  parameter int CW = 18
) (
  input  logic           clk,
  input  logic           we,
  input  logic [ADW-1:0] wa,
  input  logic [CW-1:0]  wd,
  input  logic [ADW-1:0] ra,
  output logic [CW-1:0]  rd
);

  logic [CW-1:0] mem_q [NTAP];

  // write port, updated at the clock edge
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end

  assign rd = mem_q[ra];

endmodule

// File: rtl/fir64_seq.sv
// Sequencer + MAC for a 64x12 SRL delay line; one output per input sample.
// Define FIR_SAT_EN to clip the output instead of wrapping it.
module fir64_seq
  import fir_pkg::*;
#(
  parameter int TAPS  = 64,
  parameter int CW    = 18,
  parameter int OW    = 16,
  parameter int SHIFT = 12,
  parameter int AW    = 36
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_stb,
  output logic        [DW-1:0] srl_d,
  output logic                 srl_ce,
  output logic       [ADW-1:0] srl_a,
  input  logic        [DW-1:0] srl_y,
  input  logic                 coef_we,
  input  logic       [ADW-1:0] coef_wa,
  input  logic signed [CW-1:0] coef_wd,
  output logic signed [OW-1:0] dout,
  output logic                 dout_stb,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PW = DW + CW;
  localparam logic [ADW-1:0] KLAST = ADW'(TAPS - 1);
  localparam logic signed [AW-1:0] RND = AW'(rnd_const(SHIFT));

  state_t state_q, state_d;
  logic [ADW-1:0] k_q, k_d;

  logic v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;
  logic signed [DW-1:0] tap_q, tap_d;
  logic signed [CW-1:0] coef_q, coef_d;

  logic v2_q, v2_d, f2_q, f2_d, l2_q, l2_d;
  logic signed [PW-1:0] prod_q, prod_d;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] acc_fin;
  logic signed [OW-1:0] dout_q, dout_d;
  logic stb_q, stb_d;
  logic ovr_q, ovr_d;

  logic [CW-1:0] ram_rd;

`ifdef FIR_SAT_EN
  localparam logic signed [AW-1:0] OMAX =
    {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN =
    {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  logic signed [AW-1:0] scl;
`endif

  coef_ram64x18 #(
    .CW(CW)
  ) u_ram (
    .clk(clk),
    .we (coef_we),
    .wa (coef_wa),
    .wd (coef_wd),
    .ra (k_q),
    .rd (ram_rd)
  );

  assign srl_d    = din;
  assign busy     = (state_q != IDLE);
  assign dout     = dout_q;
  assign dout_stb = stb_q;
  assign overrun  = ovr_q;

  // next state, tap counter and delay-line control
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    srl_ce  = 1'b0;
    srl_a   = '0;
    unique case (state_q)
      IDLE: begin
        srl_ce = din_stb & ~rst;
        k_d    = '0;
        if (din_stb) state_d = RUN;
      end
      RUN: begin
        srl_a = k_q;
        k_d   = k_q + 1'b1;
        if (k_q == KLAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (l2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // tap/coef capture and multiply stages; a write to the tap
  // being read this cycle is forwarded so it takes effect now
  always_comb begin
    v1_d   = (state_q == RUN);
    f1_d   = (k_q == '0);
    l1_d   = (k_q == KLAST);
    tap_d  = srl_y;
    coef_d = (coef_we && coef_wa == k_q) ? coef_wd : ram_rd;
    v2_d   = v1_q;
    f2_d   = f1_q;
    l2_d   = l1_q;
    prod_d = tap_q * coef_q;
  end

  // accumulate, then round/scale the final sum into the output
  always_comb begin
    acc_fin = $signed({{(AW-PW){prod_q[PW-1]}}, prod_q});
    if (!f2_q) acc_fin = acc_q + acc_fin;
    acc_d  = v2_q ? acc_fin : acc_q;
    stb_d  = v2_q & l2_q;
    dout_d = dout_q;
    ovr_d  = ovr_q | (din_stb & (state_q != IDLE));
`ifdef FIR_SAT_EN
    scl = (acc_fin + RND) >>> SHIFT;
    if (stb_d) begin
      if (scl > OMAX)      dout_d = OW'(OMAX);
      else if (scl < OMIN) dout_d = OW'(OMIN);
      else                 dout_d = OW'(scl);
    end
`else
    if (stb_d) dout_d = OW'((acc_fin + RND) >>> SHIFT);
`endif
  end

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ovr_q   <= ovr_d;
    end
  end

  // MAC pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      f1_q   <= 1'b0;
      l1_q   <= 1'b0;
      tap_q  <= '0;
      coef_q <= '0;
      v2_q   <= 1'b0;
      f2_q   <= 1'b0;
      l2_q   <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      f1_q   <= f1_d;
      l1_q   <= l1_d;
      tap_q  <= tap_d;
      coef_q <= coef_d;
      v2_q   <= v2_d;
      f2_q   <= f2_d;
      l2_q   <= l2_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  // output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      stb_q  <= stb_d;
    end
  end

endmodule
